inst_fetch_queue: RTL and testbench

Instruction fetch unit and instruction queue that sits directly upstream of the instruction decoder. It generates sequential fetch PCs, issues one request at a time to the instruction cache and buffers returned 32-bit instruction words with their PCs in a circular FIFO. It presents the FIFO head to the decode/issue stage with a valid/ready handshake, and supports a full redirect (flush) from the commit stage on jumps and mispredicted branches.

---
 rtl/inst_fetch_queue.sv | 133 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: sequential PC generation, single-outstanding icache
// request, and a circular queue of {inst, pc} presented to decode.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  output logic                   ic_req_valid,
  output logic [31:0]            ic_req_pc,
  input  logic                   ic_resp_valid,
  input  logic [31:0]            ic_resp_inst,
  output logic                   inst_valid,
  output logic [31:0]            inst_out,
  output logic [31:0]            inst_pc,
  input  logic                   inst_ready,
  input  logic                   flush_in,
  input  logic [31:0]            flush_pc,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               req_valid_d;
  logic [31:0]        req_pc_d;
  logic               push;
  logic               pop;
  logic               pop_ok;

  entry_t mem [DEPTH];

  assign pop_ok = (count_q != '0) && inst_ready;

  // Next-state, pointer and request logic; flush overrides every other update.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    req_valid_d = 1'b0;
    req_pc_d    = ic_req_pc;
    push        = 1'b0;
    pop         = 1'b0;

    if (flush_in) begin
      count_d    = '0;
      head_d     = tail_q;
      fetch_pc_d = flush_pc;
      case (state_q)
        WAIT, DROP: state_d = ic_resp_valid ? IDLE : DROP;
        default:    state_d = IDLE;
      endcase
    end else begin
      if (pop_ok) begin
        pop    = 1'b1;
        head_d = head_q + PTR_W'(1);
      end
      case (state_q)
        IDLE: begin
          // A slot is reserved now: occupancy can only shrink until the response.
          if ((count_q < FULL) || pop_ok) begin
            req_valid_d = 1'b1;
            req_pc_d    = fetch_pc_q;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          if (ic_resp_valid) begin
            push       = 1'b1;
            tail_d     = tail_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = IDLE;
          end
        end
        DROP: begin
          if (ic_resp_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ic_req_valid <= 1'b0;
      ic_req_pc    <= 32'h0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ic_req_valid <= req_valid_d;
      ic_req_pc    <= req_pc_d;
    end
  end

  // Queue storage carries no reset; contents are qualified by count.
  always_ff @(posedge clk_in) begin
    if (push) mem[tail_q] <= {ic_resp_inst, ic_req_pc};
  end

  assign inst_valid  = (count_q != '0);
  assign inst_out    = mem[head_q].inst;
  assign inst_pc     = mem[head_q].pc;
  assign queue_count = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a cycle table with a hand-driven icache,
// then sequences using a small latency-programmable icache model.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        ic_req_valid;
  logic [31:0] ic_req_pc;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_inst;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        flush_in   = 1'b0;
  logic [31:0] flush_pc   = 32'h0;
  logic [4:0]  queue_count;

  logic        model_en = 1'b0;
  int          lat      = 1;
  logic        m_valid  = 1'b0;
  logic [31:0] m_inst   = 32'h0;
  logic        t_valid  = 1'b0;
  logic [31:0] t_inst   = 32'h0;
  int          pend_cnt = 0;
  logic [31:0] pend_pc  = 32'h0;

  int total  = 0;
  int passed = 0;

  logic        mon_en  = 1'b0;
  logic        prev_rv = 1'b0;
  logic [31:0] exp_req = 32'h0;
  logic [31:0] exp_pop = 32'h0;
  int          pops    = 0;
  int          reqs    = 0;

  typedef struct {
    logic        resp;
    logic [31:0] rinst;
    logic        ready;
    logic        flush;
    logic [31:0] fpc;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  assign ic_resp_valid = model_en ? m_valid : t_valid;
  assign ic_resp_inst  = model_en ? m_inst  : t_inst;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .ic_req_valid  (ic_req_valid),
    .ic_req_pc     (ic_req_pc),
    .ic_resp_valid (ic_resp_valid),
    .ic_resp_inst  (ic_resp_inst),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .flush_in      (flush_in),
    .flush_pc      (flush_pc),
    .queue_count   (queue_count)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] ic_word(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  // Icache model: answers each request 'lat' cycles after the request pulse.
  always @(negedge clk_in) begin
    m_valid = 1'b0;
    if (!rst_n) begin
      pend_cnt = 0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          m_valid = 1'b1;
          m_inst  = ic_word(pend_pc);
        end
      end
      if (ic_req_valid) begin
        pend_cnt = lat;
        pend_pc  = ic_req_pc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
  endtask

  task automatic add(input logic resp, input logic [31:0] rinst, input logic ready,
                     input logic flush, input logic [31:0] fpc, input logic e_rv,
                     input logic [31:0] e_rpc, input logic e_iv, input logic [31:0] e_ipc,
                     input logic [4:0] e_cnt);
    vec_t v;
    v.resp = resp; v.rinst = rinst; v.ready = ready; v.flush = flush; v.fpc = fpc;
    v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  // One cycle; with monitoring on, scores pops and request pulses.
  task automatic tick();
    if (mon_en && inst_valid && inst_ready) begin
      chk("pop_pc", inst_pc, exp_pop);
      chk("pop_inst", inst_out, ic_word(exp_pop));
      exp_pop = exp_pop + 32'd4;
      pops++;
    end
    @(negedge clk_in);
    if (mon_en) begin
      if (ic_req_valid) begin
        chk("req_single_cycle", 32'(prev_rv), 32'd0);
        chk("req_pc_seq", ic_req_pc, exp_req);
        exp_req = exp_req + 32'd4;
        reqs++;
      end
      prev_rv = ic_req_valid;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; inst_ready = 1'b0; flush_in = 1'b0; t_valid = 1'b0;
    model_en = 1'b1; lat = 1; mon_en = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Cycle table: inputs for one cycle, outputs expected after that cycle's edge.
    //    resp rinst                  rdy flsh fpc        rv rpc        iv ipc        cnt
    add(1'b1, 32'hBAD0_0000,         1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, 5'd0);
    add(1'b1, ic_word(32'h000),      1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h000, 5'd1);
    add(1'b0, 32'h0,                 1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h000, 5'd1);
    add(1'b0, 32'h0,                 1'b0, 1'b0, 32'h0,   1'b0, 32'h004, 1'b1, 32'h000, 5'd1);
    add(1'b1, ic_word(32'h004),      1'b1, 1'b0, 32'h0,   1'b0, 32'h004, 1'b1, 32'h004, 5'd1);
    add(1'b0, 32'h0,                 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004, 5'd1);
    add(1'b1, ic_word(32'h008),      1'b1, 1'b1, 32'h200, 1'b0, 32'h008, 1'b0, 32'h000, 5'd0);
    add(1'b0, 32'h0,                 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000, 5'd0);
    add(1'b1, ic_word(32'h200),      1'b0, 1'b0, 32'h0,   1'b0, 32'h200, 1'b1, 32'h200, 5'd1);
    add(1'b0, 32'h0,                 1'b0, 1'b1, 32'h300, 1'b0, 32'h200, 1'b0, 32'h000, 5'd0);
    add(1'b0, 32'h0,                 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h000, 5'd0);
    add(1'b0, 32'h0,                 1'b0, 1'b0, 32'h0,   1'b0, 32'h300, 1'b0, 32'h000, 5'd0);
    add(1'b0, 32'h0,                 1'b0, 1'b1, 32'h400, 1'b0, 32'h300, 1'b0, 32'h000, 5'd0);
    add(1'b0, 32'h0,                 1'b0, 1'b0, 32'h0,   1'b0, 32'h300, 1'b0, 32'h000, 5'd0);
    add(1'b1, 32'hDEAD_BEEF,         1'b0, 1'b0, 32'h0,   1'b0, 32'h300, 1'b0, 32'h000, 5'd0);
    add(1'b0, 32'h0,                 1'b0, 1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h000, 5'd0);
    add(1'b1, ic_word(32'h400),      1'b0, 1'b0, 32'h0,   1'b0, 32'h400, 1'b1, 32'h400, 5'd1);
    add(1'b0, 32'h0,                 1'b1, 1'b0, 32'h0,   1'b1, 32'h404, 1'b0, 32'h000, 5'd0);
    add(1'b1, ic_word(32'h404),      1'b1, 1'b0, 32'h0,   1'b0, 32'h404, 1'b1, 32'h404, 5'd1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_req_valid", 32'(ic_req_valid), 32'd0);
    chk("rst_req_pc", ic_req_pc, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(queue_count), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      t_valid    = vq[i].resp;
      t_inst     = vq[i].rinst;
      inst_ready = vq[i].ready;
      flush_in   = vq[i].flush;
      flush_pc   = vq[i].fpc;
      @(negedge clk_in);
      chk($sformatf("v%0d_req_valid", i), 32'(ic_req_valid), 32'(vq[i].e_rv));
      chk($sformatf("v%0d_req_pc", i), ic_req_pc, vq[i].e_rpc);
      chk($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vq[i].e_iv));
      chk($sformatf("v%0d_count", i), 32'(queue_count), 32'(vq[i].e_cnt));
      if (vq[i].e_iv) begin
        chk($sformatf("v%0d_inst_pc", i), inst_pc, vq[i].e_ipc);
        chk($sformatf("v%0d_inst_out", i), inst_out, ic_word(vq[i].e_ipc));
      end
    end
    t_valid = 1'b0; inst_ready = 1'b0; flush_in = 1'b0;

    // Fill to DEPTH with no consumer, then a single pop frees one slot.
    do_reset();
    mon_en = 1'b1; prev_rv = 1'b0; exp_req = 32'h0; exp_pop = 32'h0; reqs = 0; pops = 0;
    for (int i = 0; i < 200 && queue_count != 5'd16; i++) tick();
    chk("fill_count", 32'(queue_count), 32'd16);
    repeat (10) tick();
    chk("full_no_req", 32'(ic_req_valid), 32'd0);
    chk("full_req_total", 32'(reqs), 32'd16);
    chk("full_count_hold", 32'(queue_count), 32'd16);
    chk("full_head_pc", inst_pc, 32'h0);
    chk("full_head_inst", inst_out, ic_word(32'h0));
    lat = 4;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("pop1_count", 32'(queue_count), 32'd15);
    chk("pop1_req_valid", 32'(ic_req_valid), 32'd1);
    chk("pop1_req_pc", ic_req_pc, 32'h40);
    chk("pop1_head_pc", inst_pc, 32'h4);
    chk("pop1_req_total", 32'(reqs), 32'd17);
    mon_en = 1'b0;

    // Flush while the 0x40 request is outstanding.
    flush_in = 1'b1; flush_pc = 32'h100;
    tick();
    flush_in = 1'b0; lat = 1;
    chk("flush_inst_valid", 32'(inst_valid), 32'd0);
    chk("flush_count", 32'(queue_count), 32'd0);
    for (int i = 0; i < 30 && !ic_req_valid; i++) tick();
    chk("flush_req_seen", 32'(ic_req_valid), 32'd1);
    chk("flush_req_pc", ic_req_pc, 32'h100);
    chk("flush_drop_count", 32'(queue_count), 32'd0);
    for (int i = 0; i < 30 && !inst_valid; i++) tick();
    chk("flush_first_valid", 32'(inst_valid), 32'd1);
    chk("flush_first_pc", inst_pc, 32'h100);
    chk("flush_first_inst", inst_out, ic_word(32'h100));
    chk("flush_first_count", 32'(queue_count), 32'd1);

    // Steady stream, consumer ready every other cycle, 40 instructions.
    do_reset();
    mon_en = 1'b1; prev_rv = 1'b0; exp_req = 32'h0; exp_pop = 32'h0; reqs = 0; pops = 0;
    for (int c = 0; c < 2000 && pops < 40; c++) begin
      inst_ready = (c % 2 == 1);
      tick();
    end
    inst_ready = 1'b0;
    mon_en = 1'b0;
    chk("stream_pops", 32'(pops), 32'd40);

    // Asynchronous reset while a request is outstanding with 5 entries queued.
    do_reset();
    for (int i = 0; i < 200 && queue_count != 5'd5; i++) tick();
    chk("pre_rst_count", 32'(queue_count), 32'd5);
    lat = 8;
    for (int i = 0; i < 20 && !ic_req_valid; i++) tick();
    chk("pre_rst_req_pc", ic_req_pc, 32'h14);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req_valid", 32'(ic_req_valid), 32'd0);
    chk("async_rst_req_pc", ic_req_pc, 32'h0);
    chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_count", 32'(queue_count), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1; lat = 1;
    for (int i = 0; i < 20 && !ic_req_valid; i++) tick();
    chk("post_rst_req_pc", ic_req_pc, 32'h0);
    chk("post_rst_req_valid", 32'(ic_req_valid), 32'd1);
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    chk("post_rst_inst_pc", inst_pc, 32'h0);
    chk("post_rst_inst", inst_out, ic_word(32'h0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
